// File: rtl/corr_scan_ctrl_if.sv
// Correlator handshake between the scan controller (master) and the correlator (slave):
// offset plus start pulse out, score plus finish pulse back.
interface corr_scan_ctrl_if #(
    parameter int COORD_W = 13,
    parameter int CORR_W  = 32
);
    logic               corrStart;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               corrFinished;
    logic [CORR_W-1:0]  currentCorr;

    modport master (
        output corrStart, x, y,
        input  corrFinished, currentCorr
    );

    modport slave (
        input  corrStart, x, y,
        output corrFinished, currentCorr
    );
endinterface

// File: rtl/corr_scan_ctrl.sv
// Correlation scan controller: walks a rectangular XY offset grid, requests one correlation
// per offset and keeps the best (max or min) score with its offset.
module corr_scan_ctrl #(
    parameter int COORD_W  = 13,
    parameter int CORR_W   = 32,
    parameter int X_START  = 0,
    parameter int X_LAST   = 639,
    parameter int Y_START  = 0,
    parameter int Y_LAST   = 479,
    parameter int X_STEP   = 1,
    parameter int Y_STEP   = 1,
    parameter int MODE_MIN = 0,
    parameter int HB_DIV   = 1024
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iFrameDone,
    corr_scan_ctrl_if.master   bus,
    output logic [COORD_W-1:0] oXresult,
    output logic [COORD_W-1:0] oYresult,
    output logic [CORR_W-1:0]  oBestCorr,
    output logic               oBusy,
    output logic               oDone,
    output logic               oStatusLed
);

    localparam int HB_W = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;
    localparam logic [HB_W-1:0]    HB_TOP    = HB_W'(HB_DIV - 1);
    localparam logic [COORD_W-1:0] X_START_C = COORD_W'(X_START);
    localparam logic [COORD_W-1:0] Y_START_C = COORD_W'(Y_START);
    // One extra bit keeps the advance test exact when the last offset sits at the top of the range.
    localparam logic [COORD_W:0]   X_LAST_W  = (COORD_W+1)'(X_LAST);
    localparam logic [COORD_W:0]   Y_LAST_W  = (COORD_W+1)'(Y_LAST);
    localparam logic [COORD_W:0]   X_STEP_W  = (COORD_W+1)'(X_STEP);
    localparam logic [COORD_W:0]   Y_STEP_W  = (COORD_W+1)'(Y_STEP);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state;
    state_t           stateNext;
    logic             frameDoneP1;
    logic             start;
    logic             abort;
    logic             accept;
    logic             better;
    logic             xFits;
    logic             yFits;
    logic [COORD_W:0] xNextW;
    logic [COORD_W:0] yNextW;
    logic             haveBest;
    logic [HB_W-1:0]  hbCnt;

    // Ties never win, so the earliest offset with the best score is kept.
    function automatic logic isBetter(input logic [CORR_W-1:0] score,
                                      input logic [CORR_W-1:0] cur,
                                      input logic              have);
        if (!have)
            return 1'b1;
        if (MODE_MIN != 0)
            return score < cur;
        return score > cur;
    endfunction

    always_comb begin
        start  = iFrameDone & ~frameDoneP1;
        abort  = ~iFrameDone & ((state == ISSUE) || (state == WAIT));
        accept = (state == WAIT) & bus.corrFinished & iFrameDone;
        xNextW = {1'b0, bus.x} + X_STEP_W;
        yNextW = {1'b0, bus.y} + Y_STEP_W;
        xFits  = (xNextW <= X_LAST_W);
        yFits  = (yNextW <= Y_LAST_W);
        better = isBetter(bus.currentCorr, oBestCorr, haveBest);
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:  if (start) stateNext = ISSUE;
            ISSUE: stateNext = abort ? IDLE : WAIT;
            WAIT: begin
                if (abort)
                    stateNext = IDLE;
                else if (bus.corrFinished)
                    stateNext = (xFits || yFits) ? ISSUE : DONE;
            end
            DONE:  if (start) stateNext = ISSUE;
        endcase
    end

    assign bus.corrStart = (state == ISSUE) & iFrameDone;
    assign oBusy         = (state == ISSUE) || (state == WAIT);
    assign oDone         = (state == DONE);

    // Stage p1: frame level register and FSM state
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state       <= IDLE;
            frameDoneP1 <= 1'b0;
        end else begin
            state       <= stateNext;
            frameDoneP1 <= iFrameDone;
        end
    end

    // Stage p1: scan offset and best-result tracking
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            bus.x     <= X_START_C;
            bus.y     <= Y_START_C;
            oXresult  <= '0;
            oYresult  <= '0;
            oBestCorr <= '0;
            haveBest  <= 1'b0;
        end else if (start && ((state == IDLE) || (state == DONE))) begin
            bus.x     <= X_START_C;
            bus.y     <= Y_START_C;
            oXresult  <= '0;
            oYresult  <= '0;
            oBestCorr <= '0;
            haveBest  <= 1'b0;
        end else if (accept) begin
            if (better) begin
                oBestCorr <= bus.currentCorr;
                oXresult  <= bus.x;
                oYresult  <= bus.y;
                haveBest  <= 1'b1;
            end
            if (xFits) begin
                bus.x <= xNextW[COORD_W-1:0];
            end else if (yFits) begin
                bus.x <= X_START_C;
                bus.y <= yNextW[COORD_W-1:0];
            end
        end
    end

    // Stage p1: heartbeat, survives across scans
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            hbCnt      <= '0;
            oStatusLed <= 1'b0;
        end else if (accept) begin
            if (hbCnt == HB_TOP) begin
                hbCnt      <= '0;
                oStatusLed <= ~oStatusLed;
            end else begin
                hbCnt <= hbCnt + 1'b1;
            end
        end
    end

endmodule
